sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/sync_fifo_wrap_counter.sv | 33 +++
 rtl/sync_fifo.sv | 99 +++++++++
 tb/tb_sync_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync_fifo slice.
// Default geometry and the occupancy-counter width function live here.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;

    // Occupancy spans 0..depth inclusive, hence depth+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_wrap_counter.sv
// Modulo-2^WIDTH pointer incrementer with synchronous reset and clear.
// Latency: q updates 1 cycle after en; no backpressure (always advances on en).
module wrap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with count, almost-full, flush and error pulses.
// Latency: write-to-read 1 cycle; backpressure via full/empty, rejected requests pulse overflow/underflow.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             flush;
    logic             push;
    logic             pop;

    assign flush = reset || clear;

    // Acceptance is judged on the flags registered at the start of the cycle.
    assign push = wr_en && !full  && !flush;
    assign pop  = rd_en && !empty && !flush;

    wrap_counter #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (push),
        .q     (wr_ptr)
    );

    wrap_counter #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (pop),
        .q     (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data     = mem_q[rd_ptr];
    assign count       = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_sync_fifo;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int CW       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    logic [WIDTH-1:0] model_q [$];
    bit               exp_ovf = 1'b0;
    bit               exp_udf = 1'b0;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the acceptance rules applied to its pre-edge size.
    always @(posedge clk) begin
        int  sz;
        bit  do_push;
        bit  do_pop;
        sz      = model_q.size();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        if (reset || clear) begin
            model_q.delete();
        end else begin
            do_push = wr_en && (sz < DEPTH);
            do_pop  = rd_en && (sz > 0);
            exp_ovf = wr_en && (sz == DEPTH);
            exp_udf = rd_en && (sz == 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            int sz;
            sz = model_q.size();
            chk("m_count", 64'(count), 64'(sz));
            chk("m_empty", 64'(empty), 64'(sz == 0));
            chk("m_full", 64'(full), 64'(sz == DEPTH));
            chk("m_afull", 64'(almost_full), 64'(sz >= AF_LEVEL));
            chk("m_ovf", 64'(overflow), 64'(exp_ovf));
            chk("m_udf", 64'(underflow), 64'(exp_udf));
            if (sz > 0) chk("m_rd_data", 64'(rd_data), 64'(model_q[0]));
        end
    end

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, '0, 0);
        step(0, '0, 0);
        cmp_on = 1'b1;
        reset  = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            step(1, 32'(i), 0);
            if (i == 12) chk("afull_at13", 64'(almost_full), 64'd0);
            if (i == 13) chk("afull_at14", 64'(almost_full), 64'd1);
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd16);
        step(1, 32'hFF, 0);
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        step(0, '0, 0);
        chk("ovf_drop", 64'(overflow), 64'd0);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 64'(rd_data), 64'(i));
            step(0, '0, 1);
        end
        chk("drain_empty", 64'(empty), 64'd1);
        step(0, '0, 1);
        chk("udf_pulse", 64'(underflow), 64'd1);
        chk("udf_count", 64'(count), 64'd0);

        step(1, 32'hA5, 0);
        chk("a5_data", 64'(rd_data), 64'hA5);
        chk("a5_empty", 64'(empty), 64'd0);
        step(0, '0, 1);
        chk("a5_popped", 64'(empty), 64'd1);

        // Steady state at count=8 with simultaneous push and pop.
        for (int k = 0; k < 8; k++) step(1, 32'(100 + k), 0);
        for (int i = 0; i < 40; i++) begin
            chk("stream_data", 64'(rd_data), 64'(100 + i));
            step(1, 32'(108 + i), 1);
            chk("stream_count", 64'(count), 64'd8);
        end
        for (int i = 0; i < 8; i++) begin
            chk("stream_tail", 64'(rd_data), 64'(140 + i));
            step(0, '0, 1);
        end

        // Clear overrides concurrent push/pop.
        for (int k = 0; k < 10; k++) step(1, 32'(k), 0);
        clear = 1'b1;
        step(1, 32'h77, 1);
        clear = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_empty", 64'(empty), 64'd1);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_udf", 64'(underflow), 64'd0);
        step(1, 32'h3C, 0);
        chk("clr_restart", 64'(rd_data), 64'h3C);
        step(0, '0, 1);

        // Full with push+pop: push rejected, pop accepted.
        for (int k = 0; k < 16; k++) step(1, 32'(200 + k), 0);
        step(1, 32'hEE, 1);
        chk("fullrw_ovf", 64'(overflow), 64'd1);
        chk("fullrw_count", 64'(count), 64'd15);
        chk("fullrw_udf", 64'(underflow), 64'd0);
        chk("fullrw_head", 64'(rd_data), 64'd201);
        for (int k = 0; k < 15; k++) step(0, '0, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 249) == 0);
            step(logic'($urandom_range(0, 1)), $urandom, logic'($urandom_range(0, 1)));
        end
        clear = 1'b0;
        reset = 1'b0;
        step(0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
